// File: rtl/mem_ctrl.sv
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-serial RAM sequencer shared by instruction fetch and load/store.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_read,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        ram_rw,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [2:0]  r_n;
    logic        r_own_mem;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_result;

    logic        w_mem_req;
    logic        w_abort;
    logic [2:0]  w_len_n;
    logic [31:0] w_cur_addr;
    logic [31:0] w_wshift;

    assign w_mem_req  = mem_read | mem_write;
    // Only an instruction fetch may be withdrawn; load/store always complete.
    assign w_abort    = (r_state == S_READ) && !r_own_mem && !if_read;
    assign w_cur_addr = r_base + {29'd0, r_cnt};
    assign w_wshift   = r_wdata >> {r_cnt[1:0], 3'b000};

    always_comb begin
        case (mem_len)
            2'd0:    w_len_n = 3'd1;
            2'd1:    w_len_n = 3'd2;
            default: w_len_n = 3'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        if_ready  = 1'b0;
        if_data   = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        ram_rw    = 1'b0;
        ram_a     = 32'd0;
        ram_dout  = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_req) begin
                    w_next = mem_write ? S_WRITE : S_READ;
                end else if (if_read) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (r_cnt < r_n) begin
                    ram_a = w_cur_addr;
                end
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (r_cnt == r_n) begin
                    w_next = S_DONE;
                end
            end
            S_WRITE: begin
                if (r_cnt < r_n) begin
                    ram_rw   = 1'b1;
                    ram_a    = w_cur_addr;
                    ram_dout = w_wshift[7:0];
                end
                if (r_cnt == r_n - 3'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
                if (r_own_mem) begin
                    mem_ready = 1'b1;
                    mem_rdata = r_result;
                end else begin
                    if_ready = 1'b1;
                    if_data  = r_result;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 3'd0;
            r_n       <= 3'd0;
            r_own_mem <= 1'b0;
            r_base    <= 32'd0;
            r_wdata   <= 32'd0;
            r_result  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_mem_req) begin
                        r_own_mem <= 1'b1;
                        r_base    <= mem_addr;
                        r_n       <= w_len_n;
                        r_wdata   <= mem_wdata;
                        r_result  <= 32'd0;
                    end else if (if_read) begin
                        r_own_mem <= 1'b0;
                        r_base    <= if_addr;
                        r_n       <= 3'd4;
                        r_wdata   <= 32'd0;
                        r_result  <= 32'd0;
                    end
                end
                S_READ, S_WRITE: begin
                    r_cnt <= r_cnt + 3'd1;
                    // RAM returns data one cycle late, so byte cnt-1 lands now.
                    if (r_state == S_READ) begin
                        case (r_cnt)
                            3'd1:    r_result[7:0]   <= ram_din;
                            3'd2:    r_result[15:8]  <= ram_din;
                            3'd3:    r_result[23:16] <= ram_din;
                            3'd4:    r_result[31:24] <= ram_din;
                            default: ;
                        endcase
                    end
                end
                default: r_cnt <= 3'd0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Scoreboard bench for mem_ctrl with a byte-wide RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_read;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ram_rw;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .if_read   (if_read),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_data   (if_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ram_rw    (ram_rw),
        .ram_a     (ram_a),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din)
    );

    typedef struct {
        bit          own_mem;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t sb[$];
    wr_t  wq[$];
    exp_t mon_e;
    wr_t  mon_w;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: 14-bit index is enough for the addresses used here.
    logic [7:0]  ram [0:16383];
    logic        pl_en;
    logic [31:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        ram_din <= ram[ram_a[13:0]];
        if (pl_en) ram[pl_addr[13:0]] <= pl_data;
        else if (ram_rw === 1'b1) ram[ram_a[13:0]] <= ram_dout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pl(input logic [31:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic start();
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " if_ready"},  {31'd0, if_ready},  32'd0);
        chk({tag, " mem_ready"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, " ram_rw"},    {31'd0, ram_rw},    32'd0);
        chk({tag, " ram_a"},     ram_a,              32'd0);
        chk({tag, " ram_dout"},  {24'd0, ram_dout},  32'd0);
        chk({tag, " if_data"},   if_data,            32'd0);
        chk({tag, " mem_rdata"}, mem_rdata,          32'd0);
    endtask

    task automatic wait_mem();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mem_ready === 1'b1) break;
        end
        if (mem_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL mem_ready timeout: got %b expected 1", mem_ready);
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wait_if();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (if_ready === 1'b1) break;
        end
        if (if_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL if_ready timeout: got %b expected 1", if_ready);
        end
        if_read = 1'b0;
    endtask

    task automatic mem_op(input bit wr, input logic [31:0] a, input logic [1:0] len,
                          input logic [31:0] wd);
        mem_addr = a; mem_len = len; mem_wdata = wd;
        mem_write = wr; mem_read = !wr;
        wait_mem();
    endtask

    task automatic rd_mem(input logic [31:0] a, input logic [1:0] len,
                          input logic [31:0] exp, input int lat);
        start();
        sb.push_back('{1'b1, 1'b1, exp, cyc + lat});
        mem_op(1'b0, a, len, 32'd0);
    endtask

    task automatic wr_mem(input logic [31:0] a, input logic [1:0] len,
                          input logic [31:0] wd, input int n);
        start();
        for (int i = 0; i < n; i++) begin
            logic [31:0] sh;
            sh = wd >> (8 * i);
            wq.push_back('{a + i, sh[7:0]});
        end
        sb.push_back('{1'b1, 1'b0, 32'd0, cyc + 1 + n});
        mem_op(1'b1, a, len, wd);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        start();
        sb.push_back('{1'b0, 1'b1, exp, cyc + 6});
        if_addr = a; if_read = 1'b1;
        wait_if();
    endtask

    always @(negedge clk) begin
        if (if_ready === 1'b1 || mem_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected ready: if_ready=%b mem_ready=%b expected none",
                         if_ready, mem_ready);
            end else begin
                mon_e = sb.pop_front();
                chk("ready owner", {31'd0, mem_ready}, {31'd0, mon_e.own_mem});
                chk("ready cycle", cyc, mon_e.cyc);
                if (mon_e.chk_data)
                    chk("ready data", mon_e.own_mem ? mem_rdata : if_data, mon_e.data);
            end
        end else begin
            chk("data zero outside done", if_data | mem_rdata, 32'd0);
        end
        if (ram_rw === 1'b1) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected ram write: addr %h byte %h expected none",
                         ram_a, ram_dout);
            end else begin
                mon_w = wq.pop_front();
                chk("write addr", ram_a, mon_w.addr);
                chk("write byte", {24'd0, ram_dout}, {24'd0, mon_w.data});
            end
        end else begin
            chk("ram_dout idle", {24'd0, ram_dout}, 32'd0);
        end
    end

    initial begin
        reset = 1'b1; pl_en = 1'b0; pl_addr = 32'd0; pl_data = 8'd0;
        if_read = 1'b0; if_addr = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = 32'd0;
        mem_len = 2'd0; mem_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        pl(32'h1000, 8'h13); pl(32'h1001, 8'h00); pl(32'h1002, 8'h00); pl(32'h1003, 8'h00);
        pl(32'h2000, 8'h01); pl(32'h2001, 8'h02); pl(32'h2002, 8'h03); pl(32'h2003, 8'h04);
        pl(32'h0030, 8'h80);
        pl(32'hFFFFFFFF, 8'hAB); pl(32'h0, 8'hCD); pl(32'h1, 8'hEE); pl(32'h2, 8'hEE);
        chk_all_zero("reset");
        reset = 1'b0;

        fetch(32'h1000, 32'h0000_0013);
        wr_mem(32'h20, 2'd3, 32'hDEADBEEF, 4);

        // MEM and IF raised together: MEM first, IF after DONE/IDLE.
        start();
        sb.push_back('{1'b1, 1'b1, 32'h0000_0080, cyc + 3});
        sb.push_back('{1'b0, 1'b1, 32'h0000_0013, cyc + 10});
        fork
            mem_op(1'b0, 32'h30, 2'd0, 32'd0);
            begin
                if_addr = 32'h1000; if_read = 1'b1;
                wait_if();
            end
        join

        // Fetch withdrawn after two busy cycles.
        start();
        if_addr = 32'h2000; if_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if_read = 1'b0;
        @(posedge clk); #1;
        chk("abort ram_a", ram_a, 32'd0);
        chk("abort ram_rw", {31'd0, ram_rw}, 32'd0);
        repeat (6) start();
        fetch(32'h2000, 32'h0403_0201);

        // Reset lands while the second byte is being written.
        start();
        wq.push_back('{32'h40, 8'h44});
        wq.push_back('{32'h41, 8'h33});
        mem_addr = 32'h40; mem_len = 2'd3; mem_wdata = 32'h11223344; mem_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_write = 1'b0;
        chk_all_zero("mid-write reset");
        repeat (4) start();

        // Two-byte load across the top of the address space.
        start();
        sb.push_back('{1'b1, 1'b1, 32'h0000_CDAB, cyc + 4});
        mem_addr = 32'hFFFFFFFF; mem_len = 2'd1; mem_read = 1'b1;
        @(posedge clk); #1;
        chk("wrap addr 0", ram_a, 32'hFFFFFFFF);
        chk("wrap rw 0", {31'd0, ram_rw}, 32'd0);
        @(posedge clk); #1;
        chk("wrap addr 1", ram_a, 32'h0000_0000);
        wait_mem();

        rd_mem(32'h20, 2'd3, 32'hDEADBEEF, 6);
        rd_mem(32'h20, 2'd2, 32'hDEADBEEF, 6);
        rd_mem(32'h21, 2'd0, 32'h0000_00BE, 3);
        wr_mem(32'h50, 2'd1, 32'hAAAA1234, 2);
        rd_mem(32'h50, 2'd1, 32'h0000_1234, 4);

        repeat (3) start();
        chk("scoreboard drained", sb.size(), 32'd0);
        chk("write queue drained", wq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
